// File: rtl/ex_mem_skid_reg.sv
// ============================================================================
// Module   : ex_mem_skid_reg
// Purpose  : EX->MEM pipeline register with a 2-entry skid buffer and an
//            EX->EX forwarding tap (forwarding built only with EX_MEM_FWD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_skid_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int FUNCT3_W   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic [DATA_WIDTH-1:0] in_store_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [FUNCT3_W-1:0]   in_funct3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_alu_result,
    output logic [DATA_WIDTH-1:0] out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic [FUNCT3_W-1:0]   out_funct3,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    localparam int c_BEAT_W = 2*DATA_WIDTH + REG_ADDR_W + FUNCT3_W + 3;
    // Flush keeps the data fields but zeroes funct3 and the three control flags.
    localparam logic [c_BEAT_W-1:0] c_CTRL_KEEP =
        {{(c_BEAT_W-FUNCT3_W-3){1'b1}}, {(FUNCT3_W+3){1'b0}}};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_in_ready;
    logic [c_BEAT_W-1:0]   r_main;
    logic [c_BEAT_W-1:0]   r_skid;
    logic [c_BEAT_W-1:0]   w_in_beat;
    logic                  w_accept;
    logic                  w_drain;
    logic                  w_load_main_in;
    logic                  w_load_main_skid;
    logic                  w_load_skid_in;
    logic                  w_reg_write_clean;

    assign w_reg_write_clean = in_reg_write & (in_rd != '0);
    assign w_in_beat = {in_alu_result, in_store_data, in_rd, in_funct3,
                        w_reg_write_clean, in_mem_read, in_mem_write};

    assign out_valid = (r_state != S_EMPTY);
    assign in_ready  = r_in_ready;
    assign w_accept  = in_valid & r_in_ready;
    assign w_drain   = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = S_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && !w_drain) begin
                        w_state_nxt    = S_TWO;
                        w_load_skid_in = 1'b1;
                    end else if (w_accept && w_drain) begin
                        w_load_main_in = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_drain) begin
                        w_state_nxt      = S_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // in_ready is precomputed from the next state so it never sees out_ready combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_TWO);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (flush) begin
            r_main <= r_main & c_CTRL_KEEP;
            r_skid <= r_skid & c_CTRL_KEEP;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_in_beat;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid_in) begin
                r_skid <= w_in_beat;
            end
        end
    end

    assign {out_alu_result, out_store_data, out_rd, out_funct3,
            out_reg_write, out_mem_read, out_mem_write} = r_main;

`ifdef EX_MEM_FWD_EN
    // Loads are excluded: their value is not known until MEM completes.
    assign fwd_valid = out_valid & out_reg_write & ~out_mem_read;
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_alu_result;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_skid_reg.sv
// ============================================================================
// Module   : tb_ex_mem_skid_reg
// Purpose  : Self-checking bench for ex_mem_skid_reg against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_skid_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [2:0]  out_funct3;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    ex_mem_skid_reg #(
        .DATA_WIDTH (32),
        .REG_ADDR_W (5),
        .FUNCT3_W   (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .in_funct3      (in_funct3),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_result (out_alu_result),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_funct3     (out_funct3),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
    } beat_t;

    beat_t q[$];
    bit    ctrl_zero;
    bit    all_zero;
    int    n_cmp;
    int    n_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit exp_fv;
        check_eq("out_valid", out_valid, q.size() > 0);
        check_eq("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            check_eq("alu", out_alu_result, q[0].alu);
            check_eq("store", out_store_data, q[0].sd);
            check_eq("rd", out_rd, q[0].rd);
            check_eq("reg_write", out_reg_write, q[0].rw);
            check_eq("mem_read", out_mem_read, q[0].mr);
            check_eq("mem_write", out_mem_write, q[0].mw);
            check_eq("funct3", out_funct3, q[0].f3);
        end else begin
            if (ctrl_zero) begin
                check_eq("idle_reg_write", out_reg_write, 1'b0);
                check_eq("idle_mem_read", out_mem_read, 1'b0);
                check_eq("idle_mem_write", out_mem_write, 1'b0);
            end
            if (all_zero) begin
                check_eq("rst_alu", out_alu_result, 32'd0);
                check_eq("rst_store", out_store_data, 32'd0);
                check_eq("rst_rd", out_rd, 5'd0);
                check_eq("rst_funct3", out_funct3, 3'd0);
            end
        end
`ifdef EX_MEM_FWD_EN
        exp_fv = (q.size() > 0) && q[0].rw && !q[0].mr;
        check_eq("fwd_valid", fwd_valid, exp_fv);
        if (exp_fv) begin
            check_eq("fwd_rd", fwd_rd, q[0].rd);
            check_eq("fwd_data", fwd_data, q[0].alu);
        end
`else
        exp_fv = 1'b0;
        check_eq("fwd_valid", fwd_valid, exp_fv);
        check_eq("fwd_rd", fwd_rd, 5'd0);
        check_eq("fwd_data", fwd_data, 32'd0);
`endif
    endtask

    // Model of one clock edge: bounded FIFO of depth 2, pop before push.
    task automatic model_edge();
        bit    acc;
        bit    drn;
        beat_t b;
        if (!reset) return;
        if (flush) begin
            q.delete();
            ctrl_zero = 1'b1;
            all_zero  = 1'b0;
            return;
        end
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        if (drn) void'(q.pop_front());
        if (acc) begin
            b.alu = in_alu_result;
            b.sd  = in_store_data;
            b.rd  = in_rd;
            b.rw  = in_reg_write && (in_rd != 5'd0);
            b.mr  = in_mem_read;
            b.mw  = in_mem_write;
            b.f3  = in_funct3;
            q.push_back(b);
            ctrl_zero = 1'b0;
            all_zero  = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_beat(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic mw);
        in_valid      = v;
        in_alu_result = alu;
        in_store_data = alu ^ 32'hA5A5_0000;
        in_rd         = rd;
        in_reg_write  = rw;
        in_mem_read   = mr;
        in_mem_write  = mw;
        in_funct3     = alu[2:0];
    endtask

    task automatic randomize_inputs();
        in_valid      = ($urandom_range(0, 3) != 0);
        out_ready     = ($urandom_range(0, 2) != 0);
        flush         = ($urandom_range(0, 19) == 0);
        in_alu_result = $urandom;
        in_store_data = $urandom;
        in_rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        in_reg_write  = 1'($urandom_range(0, 1));
        in_mem_read   = ($urandom_range(0, 3) == 0);
        in_mem_write  = ($urandom_range(0, 3) == 0);
        in_funct3     = 3'($urandom_range(0, 7));
    endtask

    task automatic async_reset_pulse();
        @(posedge clk);
        model_edge();
        #2 reset = 1'b0;
        q.delete();
        ctrl_zero = 1'b1;
        all_zero  = 1'b1;
        #1 check_outputs();
        set_beat(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        ctrl_zero = 1'b1;
        all_zero  = 1'b1;
        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        set_beat(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_outputs();
        reset = 1'b1;

        // First beat after reset release, forwarded ALU result.
        out_ready = 1'b1;
        set_beat(1'b1, 32'h0000_0010, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        set_beat(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Stall with two beats, then drain in order.
        out_ready = 1'b0;
        set_beat(1'b1, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        set_beat(1'b1, 32'h2, 5'd2, 1'b1, 1'b0, 1'b1);
        tick();
        set_beat(1'b1, 32'h3, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        set_beat(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (3) tick();

        // rd == 0 never writes back; loads are not forwarded.
        set_beat(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        set_beat(1'b1, 32'h0000_1000, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        set_beat(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Flush in state TWO with a simultaneous offered beat.
        out_ready = 1'b0;
        set_beat(1'b1, 32'h11, 5'd9, 1'b1, 1'b0, 1'b1);
        repeat (2) tick();
        set_beat(1'b1, 32'h99, 5'd10, 1'b1, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_beat(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (2) tick();

        // Async reset while holding two beats, then one beat passes.
        out_ready = 1'b0;
        set_beat(1'b1, 32'h21, 5'd4, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        async_reset_pulse();
        set_beat(1'b1, 32'h55, 5'd6, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        set_beat(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            tick();
            if (i == 1500) begin
                set_beat(1'b1, 32'h77, 5'd3, 1'b1, 1'b0, 1'b0);
                out_ready = 1'b0;
                flush = 1'b0;
                async_reset_pulse();
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
